// File: rtl/cp0_multi_timer.sv
// MIPS CP0: Count/Compare timers, Status/Cause/EPC, interrupt request and precise exception entry/ERET.
// Optional macro CP0_WR_BYPASS_EN forwards a same-cycle MTC0 write to the MFC0 read port.
module cp0_multi_timer #(
  parameter int          N_TIMER    = 2,
  parameter int          N_HWINT    = 6,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic               we,
  input  logic [4:0]         waddr,
  input  logic [31:0]        wdata,
  input  logic [4:0]         raddr,
  output logic [31:0]        rdata,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic               exc_bd,
  input  logic               eret,
  output logic [31:0]        epc_out,
  output logic [N_TIMER-1:0] timer_int,
  output logic               int_req
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  function automatic logic [4:0] count_addr(input int k);
    return (k == 0) ? 5'd9 : 5'(16 + 2 * (k - 1));
  endfunction

  function automatic logic [4:0] compare_addr(input int k);
    return (k == 0) ? 5'd11 : 5'(17 + 2 * (k - 1));
  endfunction

  logic [N_HWINT-1:0] hw_q;
  logic [31:0]        count_q   [N_TIMER];
  logic [31:0]        count_d   [N_TIMER];
  logic [31:0]        compare_q [N_TIMER];
  logic [31:0]        compare_d [N_TIMER];
  logic [N_TIMER-1:0] pending_q, pending_d;
  logic [31:0]        status_q, status_d;
  logic [31:0]        epc_q, epc_d;
  logic [1:0]         ip_sw_q, ip_sw_d;
  logic               bd_q, bd_d;
  logic [4:0]         exc_code_q, exc_code_d;

  logic [5:0]  ip_hw;
  logic [31:0] cause_rd;
  logic [31:0] rd_val;
  logic        rd_mapped;

  // IP[15:10]: sampled lines, with IP[15] also carrying any timer pending.
  always_comb begin
    ip_hw              = '0;
    ip_hw[N_HWINT-1:0] = hw_q;
    ip_hw[5]           = ip_hw[5] | (|pending_q);
  end

  assign cause_rd  = {bd_q, 15'b0, ip_hw, ip_sw_q, 1'b0, exc_code_q, 2'b0};
  assign int_req   = status_q[0] & ~status_q[1] & (|({ip_hw, ip_sw_q} & status_q[15:8]));
  assign epc_out   = epc_q;
  assign timer_int = pending_q;

  always_comb begin
    rd_val    = '0;
    rd_mapped = 1'b0;
    case (raddr)
      ADDR_STATUS: begin rd_val = status_q; rd_mapped = 1'b1; end
      ADDR_CAUSE:  begin rd_val = cause_rd; rd_mapped = 1'b1; end
      ADDR_EPC:    begin rd_val = epc_q;    rd_mapped = 1'b1; end
      default: ;
    endcase
    for (int k = 0; k < N_TIMER; k++) begin
      if (raddr == count_addr(k)) begin
        rd_val    = count_q[k];
        rd_mapped = 1'b1;
      end
      if (raddr == compare_addr(k)) begin
        rd_val    = compare_q[k];
        rd_mapped = 1'b1;
      end
    end
  end

`ifdef CP0_WR_BYPASS_EN
  always_comb begin
    rdata = rd_val;
    if (we && (waddr == raddr) && rd_mapped) begin
      rdata = (raddr == ADDR_CAUSE) ? {bd_q, 15'b0, ip_hw, wdata[9:8], 1'b0, exc_code_q, 2'b0}
                                    : wdata;
    end
  end
`else
  logic unused_mapped;
  assign unused_mapped = rd_mapped;
  assign rdata         = rd_val;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    ip_sw_d    = ip_sw_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    pending_d  = pending_q;

    for (int k = 0; k < N_TIMER; k++) begin
      count_d[k]   = count_q[k] + 32'd1;
      compare_d[k] = compare_q[k];
      if (we && (waddr == count_addr(k))) count_d[k] = wdata;
      if (we && (waddr == compare_addr(k))) begin
        compare_d[k] = wdata;
        pending_d[k] = 1'b0;
      end else if ((count_d[k] == compare_q[k]) && (compare_q[k] != 32'd0)) begin
        pending_d[k] = 1'b1;
      end
    end

    if (we) begin
      case (waddr)
        ADDR_STATUS: status_d = wdata;
        ADDR_CAUSE:  ip_sw_d  = wdata[9:8];
        ADDR_EPC:    epc_d    = wdata;
        default: ;
      endcase
    end

    // Exception overrides ERET, which overrides MTC0, on the fields they share.
    if (exc_valid) begin
      exc_code_d  = exc_code;
      status_d[1] = 1'b1;
      if (!status_q[1]) begin
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_bd;
      end else begin
        epc_d = epc_q;
      end
    end else if (eret) begin
      status_d[1] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      hw_q       <= '0;
      pending_q  <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      ip_sw_q    <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      // NOTE: the timer arrays are architectural registers, so they are reset like any other state.
      for (int k = 0; k < N_TIMER; k++) begin
        count_q[k]   <= '0;
        compare_q[k] <= '0;
      end
    end else begin
      hw_q       <= hw_int;
      pending_q  <= pending_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      ip_sw_q    <= ip_sw_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      for (int k = 0; k < N_TIMER; k++) begin
        count_q[k]   <= count_d[k];
        compare_q[k] <= compare_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cp0_multi_timer.sv
// Directed bench for cp0_multi_timer: register write/read table plus timer, exception and reset sequences.
module tb_cp0_multi_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic [31:0] epc_out;
  logic [1:0]  timer_int;
  logic        int_req;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cp0_multi_timer #(
    .N_TIMER    (2),
    .N_HWINT    (6),
    .STATUS_RST (32'h1000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hw_int    (hw_int),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .exc_pc    (exc_pc),
    .exc_bd    (exc_bd),
    .eret      (eret),
    .epc_out   (epc_out),
    .timer_int (timer_int),
    .int_req   (int_req)
  );

  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    raddr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"status_rw",      5'd12, 32'h1234_5678, 5'd12, 32'h1234_5678};
    vecs[1] = '{"cause_sw_only",  5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
    vecs[2] = '{"cause_clear",    5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
    vecs[3] = '{"epc_rw",         5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
    vecs[4] = '{"absent_count2",  5'd18, 32'h0000_0055, 5'd18, 32'h0000_0000};
    vecs[5] = '{"unmapped_10",    5'd10, 32'h0000_FFFF, 5'd10, 32'h0000_0000};
    vecs[6] = '{"unmapped_31",    5'd31, 32'hA5A5_A5A5, 5'd31, 32'h0000_0000};
    vecs[7] = '{"compare1_rw",    5'd17, 32'h0000_1234, 5'd17, 32'h0000_1234};
    vecs[8] = '{"compare1_zero",  5'd17, 32'h0000_0000, 5'd17, 32'h0000_0000};
    vecs[9] = '{"status_restore", 5'd12, 32'h1000_0000, 5'd12, 32'h1000_0000};

    rst = 1'b1; hw_int = '0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; eret = 1'b0;

    // Reset values; first cycle after reset deasserts
    tick(); tick();
    rst = 1'b0;
    rd(5'd12, 32'h1000_0000, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd9, 32'h0, "rst_count0");
    check("rst_timer_int", {30'b0, timer_int}, 32'h0);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    check("rst_epc_out", epc_out, 32'h0);
    tick(); tick();
    rd(5'd9, 32'd2, "count0_third_cycle");

    // Table: write one cycle, read back the next
    for (int i = 0; i < 10; i++) begin
      raddr = 5'd0;
      mtc0(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, vecs[i].exp, vecs[i].name);
    end

    // Timer 0 match and clear
    mtc0(5'd9, 32'd10);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    repeat (7) tick();
    rd(5'd9, 32'd19, "t0_count19");
    check("t0_not_yet", {30'b0, timer_int}, 32'h0);
    tick();
    rd(5'd9, 32'd20, "t0_count20");
    check("t0_pending", {30'b0, timer_int}, 32'h1);
    check("t0_int_req", {31'b0, int_req}, 32'h1);
    mtc0(5'd11, 32'd0);
    check("t0_cleared", {30'b0, timer_int}, 32'h0);
    check("t0_int_req_clr", {31'b0, int_req}, 32'h0);

    // Timer 1 wrap
    mtc0(5'd16, 32'hFFFF_FFFE);
    mtc0(5'd17, 32'd1);
    rd(5'd16, 32'hFFFF_FFFF, "t1_count_max");
    tick();
    rd(5'd16, 32'h0, "t1_wrapped");
    check("t1_no_match_at0", {30'b0, timer_int}, 32'h0);
    tick();
    check("t1_match", {30'b0, timer_int}, 32'h2);
    mtc0(5'd17, 32'd0);
    mtc0(5'd12, 32'h0);

    // Exception entry in delay slot, nested exception, ERET
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h0040_0010; exc_bd = 1'b1;
    tick();
    exc_valid = 1'b0;
    check("exc_epc_out", epc_out, 32'h0040_000C);
    rd(5'd14, 32'h0040_000C, "exc_epc_rd");
    rd(5'd13, 32'h8000_0020, "exc_cause");
    rd(5'd12, 32'h0000_0002, "exc_exl");
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_0100; exc_bd = 1'b0;
    tick();
    exc_valid = 1'b0;
    check("nested_epc", epc_out, 32'h0040_000C);
    rd(5'd13, 32'h8000_0000, "nested_cause");
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, 32'h0, "eret_exl");

    // Hardware interrupt, masked by EXL
    mtc0(5'd12, 32'h0000_1001);
    hw_int = 6'b000100;
    #1;
    check("hw_not_sampled", {31'b0, int_req}, 32'h0);
    tick();
    check("hw_int_req", {31'b0, int_req}, 32'h1);
    rd(5'd13, 32'h8000_1000, "hw_cause");
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_0200; exc_bd = 1'b0;
    tick();
    exc_valid = 1'b0;
    check("hw_exl_masks", {31'b0, int_req}, 32'h0);
    check("hw_exc_epc", epc_out, 32'h0000_0200);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    hw_int = '0;
    tick();

    // exc_valid beats a same-cycle EPC write and eret
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_0300; exc_bd = 1'b0; eret = 1'b1;
    we = 1'b1; waddr = 5'd14; wdata = 32'h0000_DEAD;
    tick();
    exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
    check("prio_epc", epc_out, 32'h0000_0300);
    rd(5'd12, 32'h0000_1003, "prio_exl");
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // Same-cycle MTC0/MFC0 to Status
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0011;
`ifdef CP0_WR_BYPASS_EN
    rd(5'd12, 32'h0000_0011, "bypass_same_cycle");
`else
    rd(5'd12, 32'h0000_1001, "no_bypass_same_cycle");
`endif
    tick();
    we = 1'b0;
    rd(5'd12, 32'h0000_0011, "status_after_write");

    // Reset mid-handler
    exc_valid = 1'b1; exc_pc = 32'h0000_0400;
    tick();
    exc_valid = 1'b0;
    rd(5'd12, 32'h0000_0013, "handler_exl");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(5'd12, 32'h1000_0000, "midrst_status");
    check("midrst_epc", epc_out, 32'h0);
    check("midrst_timer_int", {30'b0, timer_int}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
